bad_point_lut_writer: RTL and testbench
=======================================

Name: bad_point_lut_writer

Overview:
Write-side producer for the bad-point coordinate LUT, which the downstream bad-point reader walks frame by frame.
- Accepts bad-pixel coordinates from the automatic detection stage during a frame.
- Packs each into the 32-bit LUT entry format and issues one write per accepted point.
- At frame end, publishes the committed point count that the reader uses as its list length.

Parameters:
WIDTH_BITS, 10, column coordinate width
HEIGHT_BITS, 10, row coordinate width
BAD_POINT_NUM, 128, LUT depth; usable capacity is BAD_POINT_NUM-1 entries
BAD_POINT_BIT, clog2(BAD_POINT_NUM), LUT index / count width
ADDR_OFFSET, 4, register-map base added to every LUT write address

Ports:
clk  in  1  block clock; also clocks the LUT write port
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  arms collection at the next frame_start
frame_start  in  1  one-cycle pulse, first pixel of frame
frame_end  in  1  one-cycle pulse, last pixel of frame
det_valid  in  1  detected bad point present this cycle
det_x  in  WIDTH_BITS  column of detected point
det_y  in  HEIGHT_BITS  row of detected point
wen_lut  out  1  LUT write enable
waddr_lut  out  BAD_POINT_BIT  LUT write address (ADDR_OFFSET + index)
wdata_lut  out  32  packed entry: [31:16]=x zero-extended, [15:0]=y zero-extended
bad_point_num  out  BAD_POINT_BIT  committed entry count of last completed frame
commit_done  out  1  one-cycle pulse when bad_point_num updates
overflow  out  1  sticky: point dropped because LUT full
order_err  out  1  sticky: point dropped because not raster-ascending

Behaviour:
- Reset: all outputs 0; state IDLE; write index 0; last key cleared. Reset mid-frame discards the frame and the previous committed count (bad_point_num=0).
- States:
  - IDLE: det_valid ignored. frame_start & enable -> COLLECT; same cycle: index<=0, overflow<=0, order_err<=0, key-valid<=0.
  - COLLECT: accept points (rules below). frame_end -> COMMIT. frame_start -> restart COLLECT, same clearing as IDLE entry; enable is not rechecked.
  - COMMIT: one cycle. bad_point_num<=index, commit_done=1 -> IDLE.
- Accept rule in COLLECT: key = {det_y, det_x}.
  - Accepted if index < BAD_POINT_NUM-1 and (no previous key, or key >= previous key).
  - Accepted point: index+1; previous key <= key.
- Drops:
  - index == BAD_POINT_NUM-1: drop, overflow<=1.
  - key < previous key: drop, order_err<=1.
  - Both conditions in the same cycle: only overflow is set.
- Write latency: 1 cycle. wen_lut=1 on the cycle after acceptance, with registered waddr_lut = ADDR_OFFSET + pre-increment index (modulo 2^BAD_POINT_BIT) and wdata_lut. Outside writes: wen_lut=0; waddr_lut/wdata_lut hold their last value.
- det_valid coincident with frame_end: the point is accepted and included in the count. The write lands in the COMMIT cycle.
- det_valid coincident with frame_start while in COLLECT: restart first, then the point is accepted as entry 0.
- enable deassertion mid-COLLECT: the frame completes normally; it only blocks the next arm.
- bad_point_num is stable except in the COMMIT cycle.

Optional Feature:
BP_WRITER_DEDUP_EN.
- Defined: key equal to previous key is dropped silently (no write, no count, no flag).
- Undefined: equal keys are written as separate entries.

Decomposition:
- Shared package: LUT entry field positions (X_LSB=16, Y_LSB=0), ADDR_OFFSET default, state encoding constants (IDLE/COLLECT/COMMIT), and the clog2 function.
- One natural sub-module, bp_accept_filter: combinational key compare, capacity check and dedup. It outputs accept, set_overflow and set_order_err.
- FSM, index counter and write register stay in the top.

Test Plan:
- Frame with points (3,1),(7,1),(2,5), then frame_end -> three writes: addr 4,5,6; data 0x00030001, 0x00070001, 0x00020005; bad_point_num=3; commit_done one pulse.
- 130 ascending points, BAD_POINT_NUM=128 -> 127 writes (last addr 4+126 wraps to 2); overflow=1; bad_point_num=127.
- Points (5,4) then (9,2) -> second dropped; order_err=1; count=1.
- (6,6) twice -> count=2 without BP_WRITER_DEDUP_EN; count=1 with it; order_err=0 in both cases.
- det_valid on the frame_end cycle -> point counted, write in COMMIT cycle; frame_start mid-COLLECT -> index restarts, next write addr 4.
- rst_n low during COLLECT after a prior commit of 5 -> all outputs 0, bad_point_num=0; no wen_lut until next frame_start & enable.

Source files
------------

// File: rtl/bad_point_lut_writer_pkg.sv
// Shared definitions for the bad-point LUT writer: entry layout, FSM states, helpers.
package bad_point_lut_writer_pkg;

    localparam int unsigned X_LSB           = 16;
    localparam int unsigned Y_LSB           = 0;
    localparam int unsigned ADDR_OFFSET_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } bp_state_e;

    function automatic int unsigned bp_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bad_point_lut_writer_if.sv
// LUT write port bundle: the writer drives (master), the LUT storage receives (slave).
interface bad_point_lut_writer_if #(
    parameter int unsigned ADDR_BITS = 7
) ();

    logic                 wen_lut;
    logic [ADDR_BITS-1:0] waddr_lut;
    logic [31:0]          wdata_lut;

    modport master (output wen_lut, output waddr_lut, output wdata_lut);
    modport slave  (input  wen_lut, input  waddr_lut, input  wdata_lut);

endinterface

// File: rtl/bad_point_lut_writer_accept_filter.sv
// Combinational accept decision for one detected point: capacity, raster order, dedup.
// BP_WRITER_DEDUP_EN: when defined, a key equal to the previous key is dropped silently.
module bp_accept_filter #(
    parameter int unsigned KEY_BITS = 20,
    parameter int unsigned IDX_BITS = 7,
    parameter int unsigned CAPACITY = 127
) (
    input  logic                det_valid,
    input  logic [KEY_BITS-1:0] key,
    input  logic [KEY_BITS-1:0] prev_key,
    input  logic                key_valid,
    input  logic [IDX_BITS-1:0] index,
    output logic                accept,
    output logic                set_overflow,
    output logic                set_order_err
);

    always_comb begin
        accept        = 1'b0;
        set_overflow  = 1'b0;
        set_order_err = 1'b0;
        if (det_valid) begin
            // Full LUT takes priority, so an out-of-order point at capacity only flags overflow.
            if (index >= IDX_BITS'(CAPACITY)) begin
                set_overflow = 1'b1;
            end else if (key_valid && (key < prev_key)) begin
                set_order_err = 1'b1;
            end else begin
`ifdef BP_WRITER_DEDUP_EN
                accept = !(key_valid && (key == prev_key));
`else
                accept = 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/bad_point_lut_writer.sv
// Bad-point LUT writer: collects raster-ordered points per frame, writes packed entries, publishes count.
// Optional macro BP_WRITER_DEDUP_EN (see bp_accept_filter) drops repeated identical keys.
module bad_point_lut_writer
    import bad_point_lut_writer_pkg::*;
#(
    parameter int unsigned WIDTH_BITS    = 10,
    parameter int unsigned HEIGHT_BITS   = 10,
    parameter int unsigned BAD_POINT_NUM = 128,
    parameter int unsigned BAD_POINT_BIT = bp_clog2(BAD_POINT_NUM),
    parameter int unsigned ADDR_OFFSET   = ADDR_OFFSET_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     det_valid,
    input  logic [WIDTH_BITS-1:0]    det_x,
    input  logic [HEIGHT_BITS-1:0]   det_y,
    bad_point_lut_writer_if.master   lut,
    output logic [BAD_POINT_BIT-1:0] bad_point_num,
    output logic                     commit_done,
    output logic                     overflow,
    output logic                     order_err
);

    localparam int unsigned KEY_BITS = WIDTH_BITS + HEIGHT_BITS;

    bp_state_e state_q, state_d;
    logic      restart;

    logic [BAD_POINT_BIT-1:0] index_q, idx_eff;
    logic [KEY_BITS-1:0]      prev_key_q, key;
    logic                     key_valid_q, kv_eff;
    logic                     accept, set_overflow, set_order_err;

    logic                     wen_q;
    logic [BAD_POINT_BIT-1:0] waddr_q;
    logic [31:0]              wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        commit_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start && enable) begin
                    state_d = COLLECT;
                    restart = 1'b1;
                end
            end
            COLLECT: begin
                if (frame_start)    restart = 1'b1;
                else if (frame_end) state_d = COMMIT;
            end
            COMMIT: begin
                commit_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A restart clears the frame context before the same-cycle point is judged, so it lands as entry 0.
    assign key     = {det_y, det_x};
    assign idx_eff = restart ? '0   : index_q;
    assign kv_eff  = restart ? 1'b0 : key_valid_q;

    bp_accept_filter #(
        .KEY_BITS (KEY_BITS),
        .IDX_BITS (BAD_POINT_BIT),
        .CAPACITY (BAD_POINT_NUM - 1)
    ) u_filter (
        .det_valid     (det_valid && (state_q == COLLECT)),
        .key           (key),
        .prev_key      (prev_key_q),
        .key_valid     (kv_eff),
        .index         (idx_eff),
        .accept        (accept),
        .set_overflow  (set_overflow),
        .set_order_err (set_order_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q     <= '0;
            prev_key_q  <= '0;
            key_valid_q <= 1'b0;
            overflow    <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            if (accept) begin
                index_q     <= idx_eff + BAD_POINT_BIT'(1);
                prev_key_q  <= key;
                key_valid_q <= 1'b1;
            end else if (restart) begin
                index_q     <= '0;
                key_valid_q <= 1'b0;
            end
            overflow  <= (restart ? 1'b0 : overflow)  | set_overflow;
            order_err <= (restart ? 1'b0 : order_err) | set_order_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            bad_point_num <= '0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                waddr_q <= BAD_POINT_BIT'(ADDR_OFFSET) + idx_eff;
                wdata_q <= (32'(det_x) << X_LSB) | (32'(det_y) << Y_LSB);
            end
            if (state_q == COMMIT) bad_point_num <= index_q;
        end
    end

    assign lut.wen_lut   = wen_q;
    assign lut.waddr_lut = waddr_q;
    assign lut.wdata_lut = wdata_q;

endmodule

// File: tb/tb_bad_point_lut_writer.sv
// Self-checking bench for bad_point_lut_writer: expected LUT writes are queued and matched on output.
module tb_bad_point_lut_writer;

    localparam int B = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       det_valid = 1'b0;
    logic [9:0] det_x = '0;
    logic [9:0] det_y = '0;
    logic [B-1:0] bad_point_num;
    logic       commit_done, overflow, order_err;

    int checks = 0;
    int failures = 0;
    logic [B+31:0] exp_q[$];
    logic [B+31:0] exp_e;

    bad_point_lut_writer_if #(.ADDR_BITS(B)) lut_if ();

    bad_point_lut_writer #(
        .WIDTH_BITS    (10),
        .HEIGHT_BITS   (10),
        .BAD_POINT_NUM (128),
        .BAD_POINT_BIT (B),
        .ADDR_OFFSET   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .det_valid     (det_valid),
        .det_x         (det_x),
        .det_y         (det_y),
        .lut           (lut_if.master),
        .bad_point_num (bad_point_num),
        .commit_done   (commit_done),
        .overflow      (overflow),
        .order_err     (order_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && lut_if.wen_lut === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL lut_write unexpected: got addr=%0d data=%h, required none",
                         lut_if.waddr_lut, lut_if.wdata_lut);
            end else begin
                exp_e = exp_q.pop_front();
                if ({lut_if.waddr_lut, lut_if.wdata_lut} !== exp_e) begin
                    failures++;
                    $display("FAIL lut_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             lut_if.waddr_lut, lut_if.wdata_lut, exp_e[B+31:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic step(input logic fs, input logic fe, input logic dv, input int x, input int y);
        frame_start = fs;
        frame_end   = fe;
        det_valid   = dv;
        det_x       = 10'(x);
        det_y       = 10'(y);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        det_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic push(input int addr, input int x, input int y);
        exp_q.push_back({B'(addr), 16'(x), 16'(y)});
    endtask

    task automatic arm();
        enable = 1'b1;
        step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Drives frame_end; returns commit_done in the COMMIT cycle and the cycle after.
    task automatic end_frame(output logic cd_commit, output logic cd_after);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        cd_commit = commit_done;
        step(1'b0, 1'b0, 1'b0, 0, 0);
        cd_after = commit_done;
    endtask

    task automatic test_reset();
        logic [B+36:0] obs;
        rst_n = 1'b0;
        #12;
        obs = {lut_if.wen_lut, lut_if.waddr_lut, lut_if.wdata_lut, bad_point_num,
               commit_done, overflow, order_err};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", obs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        logic cd1, cd2;
        arm();
        push(4, 3, 1);  step(1'b0, 1'b0, 1'b1, 3, 1);
        push(5, 7, 1);  step(1'b0, 1'b0, 1'b1, 7, 1);
        push(6, 2, 5);  step(1'b0, 1'b0, 1'b1, 2, 5);
        checks++;
        if (commit_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_commit_early: got %b, required 0", commit_done);
        end
        end_frame(cd1, cd2);
        checks++;
        if ({cd1, cd2} !== 2'b10) begin
            failures++;
            $display("FAIL basic_commit_pulse: got %b%b, required 10", cd1, cd2);
        end
        checks++;
        if (bad_point_num !== 7'd3) begin
            failures++;
            $display("FAIL basic_count: got %0d, required 3", bad_point_num);
        end
        checks++;
        if ({overflow, order_err} !== 2'b00 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_flags: got ov=%b oe=%b pending=%0d, required 0 0 0",
                     overflow, order_err, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        logic cd1, cd2;
        arm();
        for (int i = 0; i < 130; i++) begin
            if (i < 127) push((4 + i) % 128, i, 0);
            step(1'b0, 1'b0, 1'b1, i, 0);
        end
        checks++;
        if ({overflow, order_err} !== 2'b10) begin
            failures++;
            $display("FAIL overflow_flags: got ov=%b oe=%b, required 1 0", overflow, order_err);
        end
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd127 || cd1 !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL overflow_count: got %0d cd=%b pending=%0d, required 127 1 0",
                     bad_point_num, cd1, exp_q.size());
        end
    endtask

    task automatic test_order();
        logic cd1, cd2;
        arm();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL order_arm_clears_overflow: got %b, required 0", overflow);
        end
        push(4, 5, 4);  step(1'b0, 1'b0, 1'b1, 5, 4);
        step(1'b0, 1'b0, 1'b1, 9, 2);
        checks++;
        if ({overflow, order_err} !== 2'b01) begin
            failures++;
            $display("FAIL order_flags: got ov=%b oe=%b, required 0 1", overflow, order_err);
        end
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL order_count: got %0d pending=%0d, required 1 0", bad_point_num, exp_q.size());
        end
    endtask

    task automatic test_dup();
        logic cd1, cd2;
        logic [B-1:0] exp_cnt;
        arm();
        push(4, 6, 6);
`ifdef BP_WRITER_DEDUP_EN
        exp_cnt = 7'd1;
`else
        exp_cnt = 7'd2;
        push(5, 6, 6);
`endif
        step(1'b0, 1'b0, 1'b1, 6, 6);
        step(1'b0, 1'b0, 1'b1, 6, 6);
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== exp_cnt || order_err !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL dup_count: got %0d oe=%b pending=%0d, required %0d 0 0",
                     bad_point_num, order_err, exp_q.size(), exp_cnt);
        end
    endtask

    task automatic test_frame_end_point();
        logic cd1;
        arm();
        push(4, 1, 1);  step(1'b0, 1'b0, 1'b1, 1, 1);
        push(5, 2, 1);  step(1'b0, 1'b1, 1'b1, 2, 1);
        cd1 = commit_done;
        checks++;
        if (cd1 !== 1'b1 || lut_if.wen_lut !== 1'b1) begin
            failures++;
            $display("FAIL fe_point_commit_cycle: got cd=%b wen=%b, required 1 1", cd1, lut_if.wen_lut);
        end
        idle(1);
        checks++;
        if (bad_point_num !== 7'd2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fe_point_count: got %0d pending=%0d, required 2 0", bad_point_num, exp_q.size());
        end
    endtask

    task automatic test_restart();
        logic cd1, cd2;
        arm();
        push(4, 10, 10);  step(1'b0, 1'b0, 1'b1, 10, 10);
        push(5, 11, 10);  step(1'b0, 1'b0, 1'b1, 11, 10);
        push(4, 0, 0);    step(1'b1, 1'b0, 1'b1, 0, 0);
        push(5, 1, 0);    step(1'b0, 1'b0, 1'b1, 1, 0);
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd2 || order_err !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL restart_count: got %0d oe=%b pending=%0d, required 2 0 0",
                     bad_point_num, order_err, exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        logic cd1, cd2;
        arm();
        enable = 1'b0;
        push(4, 1, 2);  step(1'b0, 1'b0, 1'b1, 1, 2);
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd1 || cd1 !== 1'b1) begin
            failures++;
            $display("FAIL enable_drop_frame: got %0d cd=%b, required 1 1", bad_point_num, cd1);
        end
        step(1'b1, 1'b0, 1'b1, 3, 3);
        step(1'b0, 1'b0, 1'b1, 4, 3);
        end_frame(cd1, cd2);
        checks++;
        if (cd1 !== 1'b0 || bad_point_num !== 7'd1) begin
            failures++;
            $display("FAIL enable_drop_no_arm: got cd=%b cnt=%0d, required 0 1", cd1, bad_point_num);
        end
    endtask

    task automatic test_reset_mid();
        logic cd1, cd2;
        logic [B+36:0] obs;
        arm();
        for (int i = 0; i < 5; i++) begin
            push(4 + i, i, 3);
            step(1'b0, 1'b0, 1'b1, i, 3);
        end
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd5) begin
            failures++;
            $display("FAIL reset_mid_prior_count: got %0d, required 5", bad_point_num);
        end
        arm();
        push(4, 8, 1);  step(1'b0, 1'b0, 1'b1, 8, 1);
        idle(1);
        rst_n = 1'b0;
        #2;
        obs = {lut_if.wen_lut, lut_if.waddr_lut, lut_if.wdata_lut, bad_point_num,
               commit_done, overflow, order_err};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h, required 0", obs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 9, 9);
        step(1'b0, 1'b1, 1'b1, 10, 9);
        idle(2);
        arm();
        push(4, 8, 8);  step(1'b0, 1'b0, 1'b1, 8, 8);
        end_frame(cd1, cd2);
        checks++;
        if (bad_point_num !== 7'd1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_rearm: got %0d pending=%0d, required 1 0", bad_point_num, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_order();
        test_dup();
        test_frame_end_point();
        test_restart();
        test_enable_drop();
        test_reset_mid();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending_writes: got %0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
